// File: rtl/unary_kernel_window_ctrl_pkg.sv
// Shared types and helpers for the unary kernel window controller:
// FSM state encoding and the bit-reversal used by the bitstream generator.
package unary_ctrl_pkg;

  localparam int BITREV_MAXW = 16;
  localparam int BITREV_IW   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] v, input int w);
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAXW; i++) begin
      if (i < w) begin
        r[i] = v[BITREV_IW'(w - 1 - i)];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/unary_kernel_window_ctrl_if.sv
// Operand/result handshake plus kernel-side signals of the window controller.
// slave is the controller's view, master is the surrounding datapath/kernel view.
interface unary_kernel_window_ctrl_if #(parameter int WIDTH = 4);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             k_rst_n;
  logic             k_in;
  logic             k_out;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready, k_out,
    input  in_ready, out_valid, out_data, k_rst_n, k_in, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, k_out,
    output in_ready, out_valid, out_data, k_rst_n, k_in, busy
  );

endinterface

// File: rtl/unary_sng_bitrev.sv
// Window counter and bit-reversed comparator stochastic number generator.
// Over any 2^WIDTH consecutive counts k_in is high for exactly opnd cycles.
module unary_sng_bitrev
  import unary_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             gen,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] cnt,
  output logic             k_in
);

  logic [WIDTH-1:0]       cnt_r;
  logic [BITREV_MAXW-1:0] rev_s;

  // Window counter: clear has priority, wraps naturally at 2^WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Upper bits of rev_s are zero, so a full-width compare equals the WIDTH-bit one
  assign rev_s = bitrev(BITREV_MAXW'(cnt_r), WIDTH);
  assign cnt   = cnt_r;
  assign k_in  = gen & (rev_s < BITREV_MAXW'(opnd));

endmodule

// File: rtl/unary_kernel_window_ctrl.sv
// Sequences a single-input unary kernel: clear, optional warm-up, then counts
// kernel output ones over a 2^WIDTH-cycle window and returns the count.
module unary_kernel_window_ctrl
  import unary_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WARMUP = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  unary_kernel_window_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_LAST  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] WARM_LAST = WIDTH'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam bit               HAS_WARM  = (WARMUP > 0);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH:0]   ones_r;
  logic [WIDTH:0]   ones_inc_s;
  logic [WIDTH:0]   out_data_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             k_rst_n_r;
  logic [WIDTH-1:0] cnt_s;
  logic             k_in_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             gen_s;
  logic             accept_s;
  logic             finish_s;
  logic             in_ready_d;
  logic             busy_d;
  logic             k_rst_n_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.in_valid) state_s = CLR;  else state_s = IDLE;
      CLR:     if (HAS_WARM)     state_s = WARM; else state_s = RUN;
      WARM:    if (cnt_s == WARM_LAST) state_s = RUN;  else state_s = WARM;
      RUN:     if (cnt_s == CNT_LAST)  state_s = DONE; else state_s = RUN;
      DONE:    if (bus.out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; handshake/kernel-reset values are precomputed from the next state
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    gen_s     = 1'b0;
    accept_s  = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: accept_s = bus.in_valid;
      CLR:  cnt_clr_s = 1'b1;
      WARM: begin
        gen_s = 1'b1;
        if (cnt_s == WARM_LAST) cnt_clr_s = 1'b1; else cnt_en_s = 1'b1;
      end
      RUN: begin
        gen_s    = 1'b1;
        cnt_en_s = 1'b1;
        finish_s = (cnt_s == CNT_LAST);
      end
      DONE:    cnt_clr_s = 1'b0;
      default: cnt_clr_s = 1'b0;
    endcase
    in_ready_d = (state_s == IDLE);
    busy_d     = (state_s == CLR) || (state_s == WARM) || (state_s == RUN);
    k_rst_n_d  = (state_s == WARM) || (state_s == RUN);
  end

  assign ones_inc_s = ones_r + {{WIDTH{1'b0}}, bus.k_out};

  // Operand, ones accumulator and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_r      <= '0;
      ones_r      <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      k_rst_n_r   <= 1'b0;
    end else begin
      in_ready_r <= in_ready_d;
      busy_r     <= busy_d;
      k_rst_n_r  <= k_rst_n_d;
      if (accept_s) opnd_r <= bus.in_data;
      if (state_r == CLR) begin
        ones_r <= '0;
      end else if (state_r == RUN) begin
        ones_r <= ones_inc_s;
      end
      // Last window cycle's k_out is folded straight into the result
      if (finish_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ones_inc_s;
      end else if ((state_r == DONE) && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  unary_sng_bitrev #(.WIDTH(WIDTH)) u_sng (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .gen   (gen_s),
    .opnd  (opnd_r),
    .cnt   (cnt_s),
    .k_in  (k_in_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.k_rst_n   = k_rst_n_r;
  assign bus.k_in      = k_in_s;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_unary_kernel_window_ctrl.sv
// Bench for unary_kernel_window_ctrl: two instances (WARMUP=0 and WARMUP=3) driven by
// randomized operands and kernel stubs, checked against a cycle-log reference model.
module tb_unary_kernel_window_ctrl;

  localparam int W    = 4;
  localparam int WIN  = 16;
  localparam int LOGN = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       rnd_bit = 1'b0;
  int         sel = 0;
  int         kmode = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         kin_log [LOGN];
  bit         kout_log[LOGN];
  bit         krst_log[LOGN];

  logic       o_in_ready, o_out_valid, o_k_rst_n, o_k_in, o_k_out, o_busy;
  logic [4:0] o_out_data;

  unary_kernel_window_ctrl_if #(.WIDTH(W)) if0 ();
  unary_kernel_window_ctrl_if #(.WIDTH(W)) if1 ();

  unary_kernel_window_ctrl #(.WIDTH(W), .WARMUP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  unary_kernel_window_ctrl #(.WIDTH(W), .WARMUP(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // kmode 0: loopback, 1: inverter, 2: random bit independent of k_in
  assign if0.in_valid  = in_valid && (sel == 0);
  assign if1.in_valid  = in_valid && (sel == 1);
  assign if0.in_data   = in_data;
  assign if1.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if0.k_out = (kmode == 0) ? if0.k_in : (kmode == 1) ? ~if0.k_in : rnd_bit;
  assign if1.k_out = (kmode == 0) ? if1.k_in : (kmode == 1) ? ~if1.k_in : rnd_bit;

  assign o_in_ready  = (sel == 1) ? if1.in_ready  : if0.in_ready;
  assign o_out_valid = (sel == 1) ? if1.out_valid : if0.out_valid;
  assign o_out_data  = (sel == 1) ? if1.out_data  : if0.out_data;
  assign o_k_rst_n   = (sel == 1) ? if1.k_rst_n   : if0.k_rst_n;
  assign o_k_in      = (sel == 1) ? if1.k_in      : if0.k_in;
  assign o_k_out     = (sel == 1) ? if1.k_out     : if0.k_out;
  assign o_busy      = (sel == 1) ? if1.busy      : if0.busy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom);
  end

  always @(negedge clk) begin
    kin_log[cyc % LOGN]  <= o_k_in;
    kout_log[cyc % LOGN] <= o_k_out;
    krst_log[cyc % LOGN] <= o_k_rst_n;
  end

  // Reference model: window = cycles t+2+w .. t+17+w after accept cycle t
  function automatic void stats(input int t, input int w, output int kin1, output int kout1, output bit rst_ok);
    kin1  = 0;
    kout1 = 0;
    rst_ok = !krst_log[(t + 1) % LOGN] && !kin_log[(t + 1) % LOGN] && !krst_log[(t + 2 + w + WIN) % LOGN];
    for (int c = t + 2; c < t + 2 + w + WIN; c++) if (!krst_log[c % LOGN]) rst_ok = 1'b0;
    for (int c = t + 2 + w; c < t + 2 + w + WIN; c++) begin
      kin1  += int'(kin_log[c % LOGN]);
      kout1 += int'(kout_log[c % LOGN]);
    end
  endfunction

  task automatic do_op(input logic [3:0] d, input bit keep, output bit ok, output int t,
                       output int lat, output logic [4:0] res, output bit saw_ready);
    ok = 1'b0; t = 0; lat = 0; res = 5'd0; saw_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_in_ready) begin t = cyc; ok = 1'b1; break; end
    end
    if (!ok) begin in_valid = 1'b0; return; end
    @(posedge clk); #1;
    if (keep) in_data = 4'($urandom); else in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_out_valid) begin ok = 1'b1; lat = cyc - t; res = o_out_data; break; end
      if (o_in_ready) saw_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = s;
        #1;
        got = {o_in_ready, o_k_rst_n, o_k_in, o_out_valid, o_busy, o_out_data};
        n_cmp++;
        if (got !== 10'b1_0_0_0_0_00000) begin
          n_fail++;
          $display("FAIL reset_state ph%0d dut%0d: got %b expected %b", ph, s, got, 10'b1000000000);
        end
      end
    end
    sel = 0;
  endtask

  task automatic test_loopback();
    bit ok, sr; int t, lat, kin1, kout1; bit rok; logic [4:0] res;
    sel = 0; kmode = 0;
    do_op(4'd11, 1'b0, ok, t, lat, res, sr);
    stats(t, 0, kin1, kout1, rok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL loopback_done: got %0d expected 1", ok); end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL loopback_latency: got %0d expected 18", lat); end
    n_cmp++; if (res !== 5'd11) begin n_fail++; $display("FAIL loopback_data: got %0d expected 11", res); end
    n_cmp++; if (kin1 !== 11) begin n_fail++; $display("FAIL loopback_kin_ones: got %0d expected 11", kin1); end
    n_cmp++; if (rok !== 1'b1) begin n_fail++; $display("FAIL loopback_k_rst_n: got %0d expected 1", rok); end
  endtask

  task automatic test_boundary();
    logic [3:0] dv[4] = '{4'd0, 4'd0, 4'd15, 4'd15};
    int km[4] = '{0, 1, 0, 1};
    int ev[4] = '{0, 16, 15, 1};
    bit ok, sr, rok; int t, lat, kin1, kout1; logic [4:0] res;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      kmode = km[i];
      do_op(dv[i], 1'b0, ok, t, lat, res, sr);
      stats(t, 0, kin1, kout1, rok);
      n_cmp++; if (res !== 5'(ev[i])) begin n_fail++; $display("FAIL boundary_data[%0d]: got %0d expected %0d", i, res, ev[i]); end
      n_cmp++; if (kin1 !== int'(dv[i])) begin n_fail++; $display("FAIL boundary_kin_ones[%0d]: got %0d expected %0d", i, kin1, dv[i]); end
    end
  endtask

  task automatic test_warmup();
    int ev[2] = '{5, 11};
    bit ok, sr, rok; int t, lat, kin1, kout1; logic [4:0] res;
    sel = 1;
    for (int i = 0; i < 2; i++) begin
      kmode = i;
      do_op(4'd5, 1'b0, ok, t, lat, res, sr);
      stats(t, 3, kin1, kout1, rok);
      n_cmp++; if (lat !== 21) begin n_fail++; $display("FAIL warmup_latency[%0d]: got %0d expected 21", i, lat); end
      n_cmp++; if (res !== 5'(ev[i])) begin n_fail++; $display("FAIL warmup_data[%0d]: got %0d expected %0d", i, res, ev[i]); end
      n_cmp++; if (rok !== 1'b1) begin n_fail++; $display("FAIL warmup_k_rst_n[%0d]: got %0d expected 1", i, rok); end
    end
    sel = 0;
  endtask

  task automatic test_random();
    bit ok, sr, rok; int t, lat, kin1, kout1, w, exp_res; logic [4:0] res; logic [3:0] d;
    for (int i = 0; i < 12; i++) begin
      sel   = int'($urandom_range(1, 0));
      kmode = int'($urandom_range(2, 0));
      d     = 4'($urandom);
      w     = (sel == 1) ? 3 : 0;
      do_op(d, 1'b0, ok, t, lat, res, sr);
      stats(t, w, kin1, kout1, rok);
      exp_res = (kmode == 0) ? int'(d) : (kmode == 1) ? (16 - int'(d)) : kout1;
      n_cmp++; if (lat !== 18 + w) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, 18 + w); end
      n_cmp++; if (res !== 5'(exp_res)) begin n_fail++; $display("FAIL random_data[%0d]: got %0d expected %0d", i, res, exp_res); end
      n_cmp++; if (kin1 !== int'(d)) begin n_fail++; $display("FAIL random_kin_ones[%0d]: got %0d expected %0d", i, kin1, d); end
    end
    sel = 0;
  endtask

  task automatic test_hold();
    bit ok, sr, stable; int t, lat, xc, acc; logic [4:0] res; logic [3:0] d;
    sel = 0; kmode = 0; out_ready = 1'b0;
    d = 4'($urandom);
    do_op(d, 1'b0, ok, t, lat, res, sr);
    stable = ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(o_out_valid === 1'b1 && o_out_data === 5'(d) && o_in_ready === 1'b0 && o_busy === 1'b0)) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %0d expected 1", stable); end
    #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'd6; xc = cyc; acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_in_ready) begin acc = cyc; break; end
    end
    n_cmp++; if (acc !== xc + 1) begin n_fail++; $display("FAIL hold_next_accept: got %0d expected %0d", acc, xc + 1); end
    n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_drop: got %0d expected 0", o_out_valid); end
    @(posedge clk); #1; in_valid = 1'b0;
    res = 5'd31;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_out_valid) begin res = o_out_data; break; end
    end
    n_cmp++; if (res !== 5'd6) begin n_fail++; $display("FAIL hold_second_data: got %0d expected 6", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok, sr, extra; int t, lat; logic [4:0] res; logic [3:0] d;
    sel = 0; kmode = 0;
    d = 4'($urandom);
    do_op(d, 1'b1, ok, t, lat, res, sr);
    n_cmp++; if (res !== 5'(d)) begin n_fail++; $display("FAIL b2b_data: got %0d expected %0d", res, d); end
    n_cmp++; if (sr !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_busy: got %0d expected 0", sr); end
    extra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_out_valid || !o_in_ready || o_busy) extra = 1'b1;
    end
    n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL b2b_single_result: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    bit ok, sr, rok, extra; int t, lat, kin1, kout1; logic [4:0] res; logic [9:0] got;
    sel = 0; kmode = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'd13; t = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_in_ready) begin t = cyc; break; end
    end
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cyc >= t + 9) break;
      @(negedge clk);
    end
    n_cmp++; if (o_k_rst_n !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_k_rst_n: got %0d expected 1", o_k_rst_n); end
    #1; rst_n = 1'b0; #1;
    got = {o_in_ready, o_k_rst_n, o_k_in, o_out_valid, o_busy, o_out_data};
    n_cmp++; if (got !== 10'b1000000000) begin n_fail++; $display("FAIL midrst_state: got %b expected %b", got, 10'b1000000000); end
    @(negedge clk); rst_n = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_out_valid || o_busy) extra = 1'b1;
    end
    n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL midrst_discarded: got %0d expected 0", extra); end
    do_op(4'd8, 1'b0, ok, t, lat, res, sr);
    stats(t, 0, kin1, kout1, rok);
    n_cmp++; if (res !== 5'd8) begin n_fail++; $display("FAIL midrst_new_data: got %0d expected 8", res); end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL midrst_new_latency: got %0d expected 18", lat); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_boundary();
    test_warmup();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
